// File: rtl/spectrum_bar_tracker.sv
// Spectrum bar tracker: per-bar height and peak registers, frame-rate decay
// with peak hold, and a registered pixel hit path for the color mapper.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | accepting magnitude samples, waiting for a frame tick
// SWEEP | one bar per cycle gets decay / peak-hold update, samples stalled
module spectrum_bar_tracker #(
  parameter int NUM_BARS  = 20,
  parameter int BAR_W     = 32,
  parameter int GAP_W     = 4,
  parameter int SCREEN_H  = 480,
  parameter int MAG_W     = 10,
  parameter int DECAY     = 4,
  parameter int PEAK_HOLD = 30
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             frame_vs,
  input  logic             mag_valid,
  output logic             mag_ready,
  input  logic [4:0]       mag_index,
  input  logic [MAG_W-1:0] mag_value,
  input  logic [9:0]       DrawX,
  input  logic [9:0]       DrawY,
  output logic             bar_on,
  output logic             peak_on,
  output logic [4:0]       bar_idx
);

  localparam int BAR_SH = $clog2(BAR_W);
  localparam int CNT_W  = $clog2(PEAK_HOLD + 1);
  localparam int S_W    = (NUM_BARS > 1) ? $clog2(NUM_BARS) : 1;

  localparam logic [9:0]       H_TOP   = 10'(SCREEN_H);
  localparam logic [9:0]       H_MAX   = 10'(SCREEN_H - 1);
  localparam logic [9:0]       DEC     = 10'(DECAY);
  localparam logic [9:0]       BAR_CNT = 10'(NUM_BARS);
  localparam logic [9:0]       OFF_MSK = 10'(BAR_W - 1);
  localparam logic [9:0]       BODY_W  = 10'(BAR_W - GAP_W);
  localparam logic [S_W-1:0]   S_LAST  = S_W'(NUM_BARS - 1);
  localparam logic [CNT_W-1:0] HOLD    = CNT_W'(PEAK_HOLD);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t           state_q, state_d;
  logic [S_W-1:0]   s_q, s_d;
  logic             vs_q, vs_d;
  logic [9:0]       h_q [NUM_BARS];
  logic [9:0]       h_d [NUM_BARS];
  logic [9:0]       p_q [NUM_BARS];
  logic [9:0]       p_d [NUM_BARS];
  logic [CNT_W-1:0] c_q [NUM_BARS];
  logic [CNT_W-1:0] c_d [NUM_BARS];
  logic             bar_on_q, bar_on_d;
  logic             peak_on_q, peak_on_d;
  logic [4:0]       bar_idx_q, bar_idx_d;

  logic frame_tick;
  logic accept;
  logic idx_ok;

  assign vs_d       = frame_vs;
  assign frame_tick = vs_q & ~frame_vs;
  assign accept     = mag_valid & mag_ready;
  assign idx_ok     = (32'(mag_index) < NUM_BARS);

  assign bar_on  = bar_on_q;
  assign peak_on = peak_on_q;
  assign bar_idx = bar_idx_q;

  // Sequencer: IDLE waits for a frame tick, SWEEP walks every bar once.
  always_comb begin
    state_d   = state_q;
    s_d       = s_q;
    mag_ready = (state_q == IDLE);
    case (state_q)
      IDLE: begin
        if (frame_tick) begin
          state_d = SWEEP;
          s_d     = '0;
        end
      end
      SWEEP: begin
        if (s_q == S_LAST) begin
          state_d = IDLE;
          s_d     = '0;
        end else begin
          s_d = s_q + S_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        s_d     = '0;
      end
    endcase
  end

  // Bar state update: samples only land in IDLE and decay only in SWEEP,
  // so the two never touch the same bar in one cycle.
  logic [9:0] t;
  logic [9:0] h_new;
  logic [9:0] p_dec;
  always_comb begin
    h_d   = h_q;
    p_d   = p_q;
    c_d   = c_q;
    t     = '0;
    h_new = '0;
    p_dec = '0;

    if (32'(mag_value) > SCREEN_H - 1) t = H_MAX;
    else                               t = 10'(mag_value);

    if (accept && idx_ok) begin
      if (t > h_q[mag_index]) h_d[mag_index] = t;
      if (t > p_q[mag_index]) begin
        p_d[mag_index] = t;
        c_d[mag_index] = HOLD;
      end
    end

    if (state_q == SWEEP) begin
      h_new = (h_q[s_q] > DEC) ? h_q[s_q] - DEC : 10'd0;
      if (c_q[s_q] != '0) begin
        c_d[s_q] = c_q[s_q] - CNT_W'(1);
        p_dec    = p_q[s_q];
      end else begin
        p_dec = (p_q[s_q] != 10'd0) ? p_q[s_q] - 10'd1 : 10'd0;
      end
      h_d[s_q] = h_new;
      // Peak marker is never allowed to sink into the bar body.
      p_d[s_q] = (p_dec > h_new) ? p_dec : h_new;
    end
  end

  // Pixel hit test against the live registers (sweep ends inside vblank).
  logic [9:0] col_full;
  logic [9:0] pix_off;
  logic [4:0] col;
  logic       in_area;
  logic [9:0] hv;
  logic [9:0] pv;
  always_comb begin
    col_full  = DrawX >> BAR_SH;
    pix_off   = DrawX & OFF_MSK;
    col       = col_full[4:0];
    in_area   = (col_full < BAR_CNT) && (pix_off < BODY_W);
    hv        = '0;
    pv        = '0;
    bar_on_d  = 1'b0;
    peak_on_d = 1'b0;
    bar_idx_d = '0;
    if (in_area) begin
      hv        = h_q[col];
      pv        = p_q[col];
      bar_idx_d = col;
      bar_on_d  = (hv != 10'd0) && (DrawY >= H_TOP - hv) && (DrawY < H_TOP);
      peak_on_d = (pv != 10'd0) && (DrawY == H_MAX - pv);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= IDLE;
      s_q       <= '0;
      vs_q      <= 1'b1;
      bar_on_q  <= 1'b0;
      peak_on_q <= 1'b0;
      bar_idx_q <= '0;
      for (int i = 0; i < NUM_BARS; i++) begin
        h_q[i] <= '0;
        p_q[i] <= '0;
        c_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      s_q       <= s_d;
      vs_q      <= vs_d;
      bar_on_q  <= bar_on_d;
      peak_on_q <= peak_on_d;
      bar_idx_q <= bar_idx_d;
      h_q       <= h_d;
      p_q       <= p_d;
      c_q       <= c_d;
    end
  end

endmodule

// File: tb/tb_spectrum_bar_tracker.sv
// Directed bench for spectrum_bar_tracker with hand-computed expectations.
module tb_spectrum_bar_tracker;

  logic       Clk;
  logic       Reset;
  logic       frame_vs;
  logic       mag_valid;
  logic       mag_ready;
  logic [4:0] mag_index;
  logic [9:0] mag_value;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       bar_on;
  logic       peak_on;
  logic [4:0] bar_idx;

  int n_vec  = 0;
  int n_miss = 0;
  int acc_cnt = 0;

  spectrum_bar_tracker dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .frame_vs  (frame_vs),
    .mag_valid (mag_valid),
    .mag_ready (mag_ready),
    .mag_index (mag_index),
    .mag_value (mag_value),
    .DrawX     (DrawX),
    .DrawY     (DrawY),
    .bar_on    (bar_on),
    .peak_on   (peak_on),
    .bar_idx   (bar_idx)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Count completed handshakes.
  always @(posedge Clk) begin
    if (!Reset && mag_valid && mag_ready) acc_cnt <= acc_cnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic pix(input string tag, input int x, input int y,
                     input int e_bar, input int e_peak, input int e_idx);
    DrawX = 10'(x);
    DrawY = 10'(y);
    step();
    chk({tag, ".bar"}, int'(bar_on), e_bar);
    chk({tag, ".peak"}, int'(peak_on), e_peak);
    chk({tag, ".idx"}, int'(bar_idx), e_idx);
  endtask

  task automatic send(input int idx, input int val);
    int n;
    n = 0;
    mag_index = 5'(idx);
    mag_value = 10'(val);
    mag_valid = 1'b1;
    while (!mag_ready && n < 100) begin
      n++;
      step();
    end
    chk("send.ready", int'(mag_ready), 1);
    step();
    mag_valid = 1'b0;
  endtask

  task automatic frame(output int n_low);
    frame_vs = 1'b0;
    step();
    frame_vs = 1'b1;
    n_low = 0;
    while (!mag_ready && n_low < 100) begin
      n_low++;
      step();
    end
  endtask

  initial begin
    int n;
    int a0;

    Reset     = 1'b1;
    frame_vs  = 1'b1;
    mag_valid = 1'b0;
    mag_index = '0;
    mag_value = '0;
    DrawX     = 10'd5;
    DrawY     = 10'd479;
    repeat (3) step();
    chk("rst.bar_on", int'(bar_on), 0);
    chk("rst.ready", int'(mag_ready), 1);
    Reset = 1'b0;
    pix("rst.pix", 5, 479, 0, 0, 0);
    chk("rst.ready2", int'(mag_ready), 1);

    // Bar 3 gets 100: body rows 380..479, peak row 379.
    a0 = acc_cnt;
    send(3, 100);
    chk("s3.acc", acc_cnt - a0, 1);
    pix("s3.y380", 100, 380, 1, 0, 3);
    pix("s3.y379", 100, 379, 0, 1, 3);

    // First tick: sweep stalls samples for 20 cycles, h=96, p held at 100.
    frame(n);
    chk("t1.stall", n, 20);
    pix("t1.y384", 100, 384, 1, 0, 3);
    pix("t1.y383", 100, 383, 0, 0, 3);
    pix("t1.y379", 100, 379, 0, 1, 3);

    // Through tick 30 the peak is still held; tick 31 drops it to 99.
    for (int k = 2; k <= 30; k++) begin
      frame(n);
      chk("tk.done", int'(mag_ready), 1);
    end
    pix("t30.peak", 100, 379, 0, 1, 3);
    frame(n);
    pix("t31.peak", 100, 380, 0, 1, 3);
    pix("t31.old", 100, 379, 0, 0, 3);
    pix("t31.hgone", 100, 479, 0, 0, 3);
    frame(n);
    pix("t32.peak", 100, 381, 0, 1, 3);

    // Clamp: 1023 to bar 0 -> height 479, peak row 0.
    send(0, 1023);
    pix("clamp.y1", 10, 1, 1, 0, 0);
    pix("clamp.y0", 10, 0, 0, 1, 0);

    // Out-of-range index: handshake completes, nothing changes.
    a0 = acc_cnt;
    send(25, 300);
    chk("idx25.acc", acc_cnt - a0, 1);
    chk("idx25.ready", int'(mag_ready), 1);
    pix("idx25.b0", 10, 1, 1, 0, 0);
    pix("idx25.b3", 100, 381, 0, 1, 3);

    // Area edges.
    pix("edge.x27", 27, 479, 1, 0, 0);
    pix("gap.x28", 28, 479, 0, 0, 0);
    pix("gap.x30", 30, 479, 0, 0, 0);
    pix("out.x640", 640, 479, 0, 0, 0);
    pix("bar19", 608, 479, 0, 0, 19);

    // mag_valid held across a tick: accept on the tick, stall 20, accept again.
    mag_index = 5'd5;
    mag_value = 10'd50;
    mag_valid = 1'b1;
    frame_vs  = 1'b0;
    a0 = acc_cnt;
    chk("hv.ready_tick", int'(mag_ready), 1);
    step();
    frame_vs = 1'b1;
    chk("hv.acc_tick", acc_cnt - a0, 1);
    n = 0;
    while (!mag_ready && n < 100) begin
      n++;
      step();
    end
    chk("hv.stall", n, 20);
    chk("hv.acc_stall", acc_cnt - a0, 1);
    step();
    mag_valid = 1'b0;
    chk("hv.acc_total", acc_cnt - a0, 2);
    pix("hv.y430", 160, 430, 1, 0, 5);
    pix("hv.y429", 160, 429, 0, 1, 5);
    pix("hv.b0y5", 10, 5, 1, 0, 0);
    pix("hv.b0y4", 10, 4, 0, 0, 0);
    pix("hv.b0pk", 10, 0, 0, 1, 0);

    // Reset at sweep cycle 7 aborts everything.
    frame_vs = 1'b0;
    step();
    frame_vs = 1'b1;
    repeat (7) step();
    chk("rs.sweeping", int'(mag_ready), 0);
    Reset = 1'b1;
    DrawX = 10'd10;
    DrawY = 10'd5;
    step();
    chk("rs.bar_in_rst", int'(bar_on), 0);
    chk("rs.ready_in_rst", int'(mag_ready), 1);
    Reset = 1'b0;
    n = 0;
    repeat (25) begin
      if (!mag_ready) n++;
      step();
    end
    chk("rs.idle", n, 0);
    pix("rs.b0", 10, 5, 0, 0, 0);
    pix("rs.b0pk", 10, 0, 0, 0, 0);
    pix("rs.b5", 160, 430, 0, 0, 5);
    pix("rs.b5pk", 160, 429, 0, 0, 5);
    pix("rs.b3pk", 100, 382, 0, 0, 3);

    // Normal operation after the abort.
    send(3, 20);
    pix("post.y460", 100, 460, 1, 0, 3);
    pix("post.y459", 100, 459, 0, 1, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
